// File: rtl/mem_stage.sv
// mem_stage: EX/MEM consumer driving data memory, stalling on dhit, resolving redirects, filling MEM/WB (optional MEM_PERF_CNT_EN adds perf counters)
module mem_stage (
    input  logic        CLK,
    input  logic        nRST,
    input  logic [31:0] ex_cpc,
    input  logic        ex_regWrite,
    input  logic        ex_memtoReg,
    input  logic        ex_halt,
    input  logic        ex_branch,
    input  logic        ex_zflag,
    input  logic        ex_dren,
    input  logic        ex_dwen,
    input  logic [1:0]  ex_jump,
    input  logic [31:0] ex_aluout,
    input  logic [31:0] ex_writeData,
    input  logic [31:0] ex_imm,
    input  logic [4:0]  ex_wsel,
    input  logic [25:0] ex_jaddr,
    input  logic        dhit,
    input  logic [31:0] dmemload,
    output logic        dmemREN,
    output logic        dmemWEN,
    output logic [31:0] dmemaddr,
    output logic [31:0] dmemstore,
    output logic        mem_stall,
    output logic        redirect,
    output logic [31:0] pc_target,
    output logic        wb_regWrite,
    output logic        wb_memtoReg,
    output logic        wb_halt,
    output logic [31:0] wb_aluout,
    output logic [31:0] wb_rdata,
    output logic [31:0] wb_cpc,
    output logic [4:0]  wb_wsel
`ifdef MEM_PERF_CNT_EN
    ,
    output logic [31:0] perf_stall_cyc,
    output logic [31:0] perf_mem_ops
`endif
);
    typedef enum logic [1:0] {IDLE, WAIT, HALTED} state_t;
    state_t state, state_n;
    logic   req, advance;

    assign dmemaddr  = ex_aluout;
    assign dmemstore = ex_writeData;

    // Request/stall/redirect decode and next-state; everything quiet in reset and after halt
    always_comb begin
        req       = (ex_dren | ex_dwen) & ~ex_halt & (state != HALTED) & nRST;
        mem_stall = req & ~dhit;
        advance   = nRST & (state != HALTED) & ~mem_stall;
        dmemREN   = req & ex_dren & ~ex_dwen;
        dmemWEN   = req & ex_dwen;
        redirect  = advance & ((ex_jump == 2'b01) | (ex_jump == 2'b10) | (ex_branch & ex_zflag));
        pc_target = (ex_jump == 2'b01) ? {ex_cpc[31:28], ex_jaddr, 2'b00} :
                    (ex_jump == 2'b10) ? ex_aluout : ex_cpc + (ex_imm << 2);
        state_n   = (state == HALTED) ? HALTED :
                    (state == WAIT)   ? (dhit ? IDLE : WAIT) :
                    mem_stall         ? WAIT :
                    (ex_halt & advance) ? HALTED : IDLE;
    end

    // State register
    always_ff @(posedge CLK) begin
        if (!nRST) state <= IDLE;
        else       state <= state_n;
    end

    // MEM/WB register: latch on advance, bubble on stall, frozen once halted
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            wb_regWrite <= 1'b0;
            wb_memtoReg <= 1'b0;
            wb_halt     <= 1'b0;
            wb_aluout   <= '0;
            wb_rdata    <= '0;
            wb_cpc      <= '0;
            wb_wsel     <= '0;
        end else if (advance) begin
            wb_regWrite <= ex_regWrite;
            wb_memtoReg <= ex_memtoReg;
            wb_halt     <= ex_halt;
            wb_aluout   <= ex_aluout;
            wb_rdata    <= dmemload;
            wb_cpc      <= ex_cpc;
            wb_wsel     <= ex_wsel;
        end else if (state != HALTED) begin
            wb_regWrite <= 1'b0;
            wb_halt     <= 1'b0;
        end
    end

`ifdef MEM_PERF_CNT_EN
    // Saturating stall-cycle and completed-access counters
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            perf_stall_cyc <= '0;
            perf_mem_ops   <= '0;
        end else begin
            perf_stall_cyc <= perf_stall_cyc + {31'b0, mem_stall & ~&perf_stall_cyc};
            perf_mem_ops   <= perf_mem_ops + {31'b0, req & dhit & ~&perf_mem_ops};
        end
    end
`endif
endmodule
